// File: rtl/fsm_key_pkg.sv
// rtl/fsm_key_pkg.sv - shared state encoding and default sizes for the key scheduler
package fsm_key_pkg;

  localparam int KEY_W_DEF = 11;
  localparam int DEPTH_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } key_state_e;

endpackage

// File: rtl/key_slot_rf.sv
// rtl/key_slot_rf.sv - key slot register file, one write port, one async read port
module key_slot_rf #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Reset clears every slot so a stale key never survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fsm_key_scheduler.sv
// rtl/fsm_key_scheduler.sv - time-varying key sequencer for locked small-FSM benchmarks
// Optional slot parity checking is enabled by defining KEY_SCHED_PARITY_EN.
module fsm_key_scheduler
  import fsm_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [KEY_W-1:0] cfg_data,
  input  logic             len_we,
  input  logic [IDX_W:0]   len_data,
  input  logic             len_loop,
  input  logic             start,
  input  logic             stop,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic [IDX_W-1:0] step,
  output logic             busy,
  output logic             done,
  output logic             wr_rej,
  output logic             err
);

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  key_state_e       state;
  logic [IDX_W:0]   seq_len;
  logic             loop_en;
  logic             wr_open, cfg_wr, len_wr, last, par_err;
  logic [IDX_W:0]   len_clamp, len_eff;
  logic [KEY_W-1:0] rd_key;

  assign wr_open   = (state != RUN);
  assign cfg_wr    = cfg_we & wr_open;
  assign len_wr    = len_we & wr_open;
  assign len_clamp = (len_data > DEPTH_L) ? DEPTH_L : len_data;
  // A length written alongside start must govern that start.
  assign len_eff   = len_wr ? len_clamp : seq_len;
  assign last      = ({1'b0, step} == (seq_len - 1'b1));

`ifdef KEY_SCHED_PARITY_EN
  logic [KEY_W:0] rd_word;
  logic           err_q;

  key_slot_rf #(.WIDTH(KEY_W+1), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_rf (
    .clk(clk), .rst(rst), .we(cfg_wr), .waddr(cfg_addr),
    .wdata({^cfg_data, cfg_data}), .raddr(step), .rdata(rd_word)
  );

  assign rd_key  = rd_word[KEY_W-1:0];
  assign par_err = (state != IDLE) && (^rd_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (par_err) err_q <= 1'b1;
  end

  assign err = err_q | par_err;
`else
  key_slot_rf #(.WIDTH(KEY_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_rf (
    .clk(clk), .rst(rst), .we(cfg_wr), .waddr(cfg_addr),
    .wdata(cfg_data), .raddr(step), .rdata(rd_key)
  );

  assign par_err = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      step    <= '0;
      seq_len <= '0;
      loop_en <= 1'b0;
      done    <= 1'b0;
      wr_rej  <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_rej <= (cfg_we | len_we) & ~wr_open;
      if (len_wr) begin
        seq_len <= len_clamp;
        loop_en <= len_loop;
      end
      case (state)
        IDLE: begin
          if (start && !stop && len_eff != '0) begin
            state <= RUN;
            step  <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            step  <= '0;
          end else if (last) begin
            if (loop_en) begin
              step <= '0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            step <= step + 1'b1;
          end
        end
        DONE: begin
          if (stop) begin
            state <= IDLE;
            step  <= '0;
          end else if (start && len_eff != '0) begin
            state <= RUN;
            step  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          step  <= '0;
        end
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign key_valid = (state != IDLE);
  // The slot is read combinationally so a write landing with start is seen by the first key.
  assign key_out   = (key_valid && !err) ? rd_key : '0;

endmodule

// File: tb/tb_fsm_key_scheduler.sv
// tb/tb_fsm_key_scheduler.sv - directed self-checking bench for fsm_key_scheduler
module tb_fsm_key_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, len_we, len_loop, start, stop;
  logic [2:0]  cfg_addr;
  logic [10:0] cfg_data;
  logic [3:0]  len_data;
  logic [10:0] key_out;
  logic        key_valid, busy, done, wr_rej, err;
  logic [2:0]  step;

  int n_chk  = 0;
  int n_pass = 0;

  logic [10:0] pat [4] = '{11'h001, 11'h002, 11'h004, 11'h008};

  fsm_key_scheduler dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .len_we(len_we), .len_data(len_data), .len_loop(len_loop),
    .start(start), .stop(stop),
    .key_out(key_out), .key_valid(key_valid), .step(step),
    .busy(busy), .done(done), .wr_rej(wr_rej), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_slot(input logic [2:0] a, input logic [10:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_len(input logic [3:0] l, input logic lp);
    len_we = 1'b1; len_data = l; len_loop = lp;
    tick();
    len_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 0; len_we = 0; len_loop = 0; start = 0; stop = 0;
    cfg_addr = '0; cfg_data = '0; len_data = '0;
    tick(); tick();
    chk("rst_key", key_out, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step, 0);
    chk("rst_wr_rej", wr_rej, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // one-shot sequence of four keys
    for (int i = 0; i < 4; i++) wr_slot(3'(i), pat[i]);
    set_len(4'd4, 1'b0);
    go();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_key%0d", i), key_out, pat[i]);
      chk($sformatf("t1_step%0d", i), step, i);
      chk($sformatf("t1_busy%0d", i), busy, 1);
      chk($sformatf("t1_done%0d", i), done, 0);
      tick();
    end
    chk("t1_done_pulse", done, 1);
    chk("t1_done_key", key_out, 11'h008);
    chk("t1_done_busy", busy, 0);
    chk("t1_done_valid", key_valid, 1);
    tick();
    chk("t1_done_clr", done, 0);
    chk("t1_hold_key", key_out, 11'h008);

    // looping sequence, then stop
    set_len(4'd4, 1'b1);
    go();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t2_key%0d", i), key_out, pat[i % 4]);
      chk($sformatf("t2_busy%0d", i), busy, 1);
      if (i < 8) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_stop_key", key_out, 0);
    chk("t2_stop_valid", key_valid, 0);
    chk("t2_stop_busy", busy, 0);
    chk("t2_stop_step", step, 0);

    // write during RUN is rejected
    go();
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 11'h7ff;
    tick();
    cfg_we = 1'b0;
    chk("t3_wr_rej", wr_rej, 1);
    chk("t3_step1", step, 1);
    tick();
    chk("t3_wr_rej_clr", wr_rej, 0);
    chk("t3_slot_kept", key_out, 11'h004);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // zero length ignored; length one is a single RUN cycle
    set_len(4'd0, 1'b0);
    go();
    chk("t4_len0_busy", busy, 0);
    chk("t4_len0_valid", key_valid, 0);
    set_len(4'd1, 1'b0);
    go();
    chk("t4_len1_busy", busy, 1);
    chk("t4_len1_key", key_out, 11'h001);
    tick();
    chk("t4_len1_busy_off", busy, 0);
    chk("t4_len1_done", done, 1);
    chk("t4_len1_hold", key_out, 11'h001);

    // write coincident with start is used by the first key
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 11'h055; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    chk("t4_wr_start_key", key_out, 11'h055);
    chk("t4_wr_start_busy", busy, 1);
    tick();

    // oversize length clamps to DEPTH
    set_len(4'd15, 1'b0);
    go();
    for (int i = 0; i < 7; i++) tick();
    chk("t4_clamp_step7", step, 7);
    chk("t4_clamp_busy7", busy, 1);
    tick();
    chk("t4_clamp_done", done, 1);
    chk("t4_clamp_step_hold", step, 7);

    // asynchronous reset mid-RUN clears slots
    stop = 1'b1;
    tick();
    stop = 1'b0;
    set_len(4'd4, 1'b0);
    go();
    tick(); tick();
    chk("t5_pre_step", step, 2);
    rst = 1'b1;
    #1;
    chk("t5_rst_key", key_out, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", key_valid, 0);
    tick();
    rst = 1'b0;
    set_len(4'd4, 1'b0);
    go();
    chk("t5_cleared_valid", key_valid, 1);
    chk("t5_cleared_key", key_out, 0);

`ifdef KEY_SCHED_PARITY_EN
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wr_slot(3'd0, 11'h001);
    wr_slot(3'd1, 11'h002);
    dut.u_rf.mem[1] = dut.u_rf.mem[1] ^ 12'h001;
    go();
    chk("t6_key0", key_out, 11'h001);
    chk("t6_err0", err, 0);
    tick();
    chk("t6_err1", err, 1);
    chk("t6_key1", key_out, 0);
    tick();
    chk("t6_err_sticky", err, 1);
    chk("t6_key2", key_out, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
